// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard for an in-order
// issue stage. Each architectural register owns a saturating pending-write
// counter; sources with pending writes stall the issue, and so does a
// destination whose counter is already saturated. Register 0 never goes busy.
//
// Optional feature, selected by macro HAZARD_SCOREBOARD_WB_BYPASS_EN:
//   when defined, a source whose last pending write retires in the same
//   cycle does not stall. Undefined (default): stalls use only the
//   registered busy vector.
module hazard_scoreboard #(
  parameter  int DEPTH = 32,
  parameter  int CNT_W = 2,
  localparam int BITS  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_we,
  input  logic [BITS-1:0]  issue_rd,
  input  logic [BITS-1:0]  issue_rs1,
  input  logic [BITS-1:0]  issue_rs2,
  input  logic             issue_rs1_en,
  input  logic             issue_rs2_en,
  input  logic             wb_valid,
  input  logic [BITS-1:0]  wb_rd,
  output logic [DEPTH-1:0] busy,
  output logic             wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]            rd_oh;
  logic [DEPTH-1:0]            wb_oh;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_all;
  logic [DEPTH-1:0]            busy_all;
  logic [DEPTH-1:0]            wb_zero;
  logic                        fire;
  logic                        wb_err_reg;
  logic                        rs1_bypass;
  logic                        rs2_bypass;

  // One-hot decode of the issue destination and the writeback destination.
  always_comb begin
    rd_oh           = '0;
    wb_oh           = '0;
    rd_oh[issue_rd] = 1'b1;
    wb_oh[wb_rd]    = 1'b1;
  end

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  // A source whose only pending write retires this cycle may issue now.
  always_comb begin
    rs1_bypass = wb_valid && (wb_rd == issue_rs1) && (cnt_all[issue_rs1] == CNT_W'(1));
    rs2_bypass = wb_valid && (wb_rd == issue_rs2) && (cnt_all[issue_rs2] == CNT_W'(1));
  end
`else
  // Without bypass a same-cycle writeback only unblocks on the next cycle.
  always_comb begin
    rs1_bypass = 1'b0;
    rs2_bypass = 1'b0;
  end
`endif

  // Stall on busy sources or a saturated destination; independent of issue_valid.
  always_comb begin
    issue_ready = 1'b1;
    if (issue_rs1_en && busy_all[issue_rs1] && !rs1_bypass)
      issue_ready = 1'b0;
    if (issue_rs2_en && busy_all[issue_rs2] && !rs2_bypass)
      issue_ready = 1'b0;
    if (issue_we && (cnt_all[issue_rd] == CNT_MAX))
      issue_ready = 1'b0;
  end

  assign fire = issue_valid && issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Register 0 is hardwired: never pending, never flags an error.
        assign cnt_all[gi]  = '0;
        assign busy_all[gi] = 1'b0;
        assign wb_zero[gi]  = 1'b0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             busy_reg;
        logic             inc;
        logic             wb_hit;

        assign inc    = fire && issue_we && rd_oh[gi];
        assign wb_hit = wb_valid && wb_oh[gi];

        // Next count: simultaneous issue and writeback cancel; never wraps.
        always_comb begin
          cnt_next = cnt_reg;
          if (inc && !wb_hit)
            cnt_next = cnt_reg + 1'b1;
          else if (!inc && wb_hit && (cnt_reg != '0))
            cnt_next = cnt_reg - 1'b1;
        end

        // Counter and its busy bit, cleared asynchronously by reset.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
          end else begin
            cnt_reg  <= cnt_next;
            busy_reg <= (cnt_next != '0);
          end
        end

        assign cnt_all[gi]  = cnt_reg;
        assign busy_all[gi] = busy_reg;
        assign wb_zero[gi]  = wb_hit && (cnt_reg == '0);
      end
    end
  endgenerate

  // Sticky error: any writeback to a register with nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_err_reg <= 1'b0;
    else if (|wb_zero)
      wb_err_reg <= 1'b1;
  end

  assign busy   = busy_all;
  assign wb_err = wb_err_reg;

endmodule
